screen_mapper: RTL and testbench

SCREEN_MAPPER -- requirements
Module: screen_mapper

---
 rtl/screen_mapper_if.sv | 38 +++
 rtl/screen_mapper.sv | 208 ++++++++++++++++++++
 tb/tb_screen_mapper.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/screen_mapper_if.sv
// screen_mapper_if: batch handshake and data bus between a vertex producer (master) and the
// screen mapper (slave).
//   data_valid    master->slave  batch present (sampled only while ready)
//   mode          master->slave  0 = perspective divide by w, 1 = orthographic
//   clip_in       master->slave  x,y,z,w per vertex, signed Q(W-FRAC).FRAC
//   vp_scale      master->slave  viewport sx, sy
//   vp_offset     master->slave  viewport ox, oy
//   read_done     master->slave  consumer release (sampled only while calc_done)
//   ready         slave->master  mapper idle and able to accept a batch
//   calc_done     slave->master  results valid, held until read_done
//   screen_2d_out slave->master  screen x,y per vertex
//   clipped_out   slave->master  per-vertex reject flag
interface screen_mapper_if #(
  parameter int unsigned NVERT = 3,
  parameter int unsigned W     = 32,
  parameter int unsigned FRAC  = 16
);
  logic                             data_valid;
  logic                             mode;
  logic [NVERT-1:0][3:0][W-1:0]     clip_in;
  logic [1:0][W-1:0]                vp_scale;
  logic [1:0][W-1:0]                vp_offset;
  logic                             read_done;
  logic                             ready;
  logic                             calc_done;
  logic [NVERT-1:0][1:0][W-1:0]     screen_2d_out;
  logic [NVERT-1:0]                 clipped_out;

  modport master (
    output data_valid, mode, clip_in, vp_scale, vp_offset, read_done,
    input  ready, calc_done, screen_2d_out, clipped_out
  );

  modport slave (
    input  data_valid, mode, clip_in, vp_scale, vp_offset, read_done,
    output ready, calc_done, screen_2d_out, clipped_out
  );
endinterface

// File: rtl/screen_mapper.sv
// screen_mapper: maps a batch of clip-space vertices to screen coordinates.
// Each x/y component is (optionally) divided by w with a serial restoring divider, then scaled
// and offset by the viewport. Components are processed one at a time, vertex 0 x first.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  screen_mapper_if slave modport (batch handshake, inputs, results)
module screen_mapper #(
  parameter int unsigned NVERT = 3,
  parameter int unsigned W     = 32,
  parameter int unsigned FRAC  = 16
) (
  input logic             clk,
  input logic             rst,
  screen_mapper_if.slave  bus
);

  localparam int unsigned QW = W + FRAC;
  localparam int unsigned VW = (NVERT > 1) ? $clog2(NVERT) : 1;
  localparam int unsigned IW = $clog2(QW + 1);

  // Quotient magnitude limits for the two signs of the result.
  localparam logic [QW-1:0] QMaxPos = {{(FRAC + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [QW-1:0] QMaxNeg = {{FRAC{1'b0}}, 1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0]  SatPos  = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  SatNeg  = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, SCALE, DONE} state_e;

  state_e                        r_state;
  logic                          r_ready;
  logic                          r_calc_done;
  logic [NVERT-1:0][3:0][W-1:0]  r_clip;
  logic [1:0][W-1:0]             r_scale;
  logic [1:0][W-1:0]             r_offset;
  logic                          r_mode;
  logic [VW-1:0]                 r_vert;
  logic                          r_axis;
  logic                          r_cur_clip;
  logic                          r_divided;
  logic [W-1:0]                  r_ndc;
  logic [W-1:0]                  r_rem;
  logic [QW-1:0]                 r_quo;
  logic [W-1:0]                  r_dsr;
  logic                          r_neg;
  logic [IW-1:0]                 r_itr;
  logic [NVERT-1:0][1:0][W-1:0]  r_screen;
  logic [NVERT-1:0]              r_clipped;

  // Current component and its vertex's w.
  logic [W-1:0] w_comp;
  logic [W-1:0] w_wcomp;
  logic         w_is_clip;
  logic [W-1:0] w_abs_c;
  logic [W-1:0] w_abs_w;

  assign w_comp    = r_clip[r_vert][{1'b0, r_axis}];
  assign w_wcomp   = r_clip[r_vert][3];
  assign w_is_clip = !r_mode && (w_wcomp[W-1] || (w_wcomp == '0));
  assign w_abs_c   = w_comp[W-1] ? ('0 - w_comp) : w_comp;
  assign w_abs_w   = w_wcomp[W-1] ? ('0 - w_wcomp) : w_wcomp;

  // One restoring-divide step. The remainder stays below the divisor, so the low W bits of the
  // difference are exact whenever the subtraction is taken.
  logic [W:0]   w_rem_sh;
  logic         w_ge;
  logic [W-1:0] w_diff;

  assign w_rem_sh = {r_rem, r_quo[QW-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dsr});
  assign w_diff   = w_rem_sh[W-1:0] - r_dsr;

  // Signed, saturated divide result.
  logic [W-1:0] w_q_sat;
  always_comb begin
    w_q_sat = r_quo[W-1:0];
    if (r_neg) begin
      w_q_sat = (r_quo > QMaxNeg) ? SatNeg : ('0 - r_quo[W-1:0]);
    end else if (r_quo > QMaxPos) begin
      w_q_sat = SatPos;
    end
  end

  // Viewport transform: full-width product, floor shift, saturated add.
  logic [W-1:0]            w_ndc;
  logic [W-1:0]            w_s;
  logic [W-1:0]            w_o;
  logic signed [2*W-1:0]   w_ndc_x;
  logic signed [2*W-1:0]   w_s_x;
  logic signed [2*W-1:0]   w_prod;
  logic signed [2*W-1:0]   w_shift;
  logic [2*W:0]            w_sum;
  logic                    w_fits;
  logic [W-1:0]            w_scaled;

  assign w_ndc    = r_divided ? w_q_sat : r_ndc;
  assign w_s      = r_scale[r_axis];
  assign w_o      = r_offset[r_axis];
  assign w_ndc_x  = {{W{w_ndc[W-1]}}, w_ndc};
  assign w_s_x    = {{W{w_s[W-1]}}, w_s};
  assign w_prod   = w_ndc_x * w_s_x;
  assign w_shift  = w_prod >>> FRAC;
  assign w_sum    = {w_shift[2*W-1], w_shift} + {{(W + 1){w_o[W-1]}}, w_o};
  // Fits in W signed bits when every bit above the result sign matches it.
  assign w_fits   = (w_sum[2*W:W-1] == '0) || (w_sum[2*W:W-1] == '1);
  assign w_scaled = w_fits ? w_sum[W-1:0] : (w_sum[2*W] ? SatNeg : SatPos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_calc_done <= 1'b0;
      r_clip      <= '0;
      r_scale     <= '0;
      r_offset    <= '0;
      r_mode      <= 1'b0;
      r_vert      <= '0;
      r_axis      <= 1'b0;
      r_cur_clip  <= 1'b0;
      r_divided   <= 1'b0;
      r_ndc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_neg       <= 1'b0;
      r_itr       <= '0;
      r_screen    <= '0;
      r_clipped   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.data_valid) begin
            r_clip    <= bus.clip_in;
            r_scale   <= bus.vp_scale;
            r_offset  <= bus.vp_offset;
            r_mode    <= bus.mode;
            r_clipped <= '0;
            r_vert    <= '0;
            r_axis    <= 1'b0;
            r_ready   <= 1'b0;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (w_is_clip) begin
            r_clipped[r_vert] <= 1'b1;
            r_cur_clip        <= 1'b1;
            r_divided         <= 1'b0;
            r_state           <= SCALE;
          end else if (r_mode) begin
            r_ndc      <= w_comp;
            r_cur_clip <= 1'b0;
            r_divided  <= 1'b0;
            r_state    <= SCALE;
          end else begin
            r_rem      <= '0;
            r_quo      <= {w_abs_c, {FRAC{1'b0}}};
            r_dsr      <= w_abs_w;
            r_neg      <= w_comp[W-1] ^ w_wcomp[W-1];
            r_itr      <= '0;
            r_cur_clip <= 1'b0;
            r_divided  <= 1'b1;
            r_state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[W-1:0];
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_itr <= r_itr + IW'(1);
          if (r_itr == IW'(QW - 1)) begin
            r_state <= SCALE;
          end
        end
        SCALE: begin
          r_screen[r_vert][r_axis] <= r_cur_clip ? '0 : w_scaled;
          r_axis                   <= ~r_axis;
          if (r_axis && (r_vert == VW'(NVERT - 1))) begin
            r_calc_done <= 1'b1;
            r_state     <= DONE;
          end else begin
            if (r_axis) begin
              r_vert <= r_vert + VW'(1);
            end
            r_state <= LOAD;
          end
        end
        DONE: begin
          if (bus.read_done) begin
            r_calc_done <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_calc_done <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready         = r_ready;
  assign bus.calc_done     = r_calc_done;
  assign bus.screen_2d_out = r_screen;
  assign bus.clipped_out   = r_clipped;

endmodule

// File: tb/tb_screen_mapper.sv
// tb_screen_mapper: directed self-checking bench for screen_mapper with default parameters.
module tb_screen_mapper;
  localparam int unsigned NVERT = 3;
  localparam int unsigned W     = 32;
  localparam int unsigned FRAC  = 16;

  localparam logic [31:0] ONE   = 32'h0001_0000;
  localparam logic [31:0] TWO   = 32'h0002_0000;
  localparam logic [31:0] FIVE  = 32'h0005_0000;
  localparam logic [31:0] HALF  = 32'h0000_8000;
  localparam logic [31:0] MONE  = 32'hFFFF_0000;
  localparam logic [31:0] MTWO  = 32'hFFFE_0000;
  localparam logic [31:0] MHALF = 32'hFFFF_8000;
  localparam logic [31:0] S320  = 32'h0140_0000;
  localparam logic [31:0] P160  = 32'h00A0_0000;
  localparam logic [31:0] P480  = 32'h01E0_0000;
  localparam logic [31:0] P640  = 32'h0280_0000;
  localparam logic [31:0] P960  = 32'h03C0_0000;

  logic clk = 1'b0;
  logic rst;

  screen_mapper_if #(.NVERT(NVERT), .W(W), .FRAC(FRAC)) bus ();

  screen_mapper #(.NVERT(NVERT), .W(W), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_vert(input string tag, input int v, input logic [31:0] ex,
                          input logic [31:0] ey);
    chk($sformatf("%s v%0d x", tag, v), bus.screen_2d_out[v][0], ex);
    chk($sformatf("%s v%0d y", tag, v), bus.screen_2d_out[v][1], ey);
  endtask

  task automatic set_vert(input int v, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] w);
    bus.clip_in[v][0] = x;
    bus.clip_in[v][1] = y;
    bus.clip_in[v][2] = '0;
    bus.clip_in[v][3] = w;
  endtask

  task automatic set_vp(input logic [31:0] s, input logic [31:0] o);
    bus.vp_scale[0]  = s;
    bus.vp_scale[1]  = s;
    bus.vp_offset[0] = o;
    bus.vp_offset[1] = o;
  endtask

  // Returns #1 after the capturing edge.
  task automatic capture(input bit hold);
    @(negedge clk);
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.data_valid = 1'b0;
  endtask

  // Counts edges after the capturing edge until calc_done is seen; optional read_done noise
  // lands inside the first component's divide.
  task automatic wait_done(input string tag, input int exp_lat, input bit noise);
    int lat;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      bus.read_done = noise && (n >= 5) && (n < 15);
      if (bus.calc_done) begin
        lat = n;
        break;
      end
    end
    bus.read_done = 1'b0;
    chk(tag, lat, exp_lat);
  endtask

  task automatic release_batch(input bit dv);
    @(negedge clk);
    bus.read_done  = 1'b1;
    bus.data_valid = dv;
    @(posedge clk);
    #1;
    bus.read_done = 1'b0;
  endtask

  task automatic load_t1;
    bus.mode = 1'b0;
    set_vp(S320, S320);
    set_vert(0, TWO, MONE, TWO);
    set_vert(1, '0, '0, TWO);
    set_vert(2, MTWO, ONE, TWO);
  endtask

  // x=2/2=1 -> 640; y=-1/2=-0.5 -> -160+320 = 160; v1 0 -> 320; v2 -1 -> 0, 0.5 -> 480.
  task automatic chk_t1(input string tag);
    chk_vert(tag, 0, P640, P160);
    chk_vert(tag, 1, S320, S320);
    chk_vert(tag, 2, '0, P480);
    chk({tag, " clipped"}, bus.clipped_out, 3'b000);
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.read_done  = 1'b0;
    bus.mode       = 1'b0;
    bus.clip_in    = '0;
    bus.vp_scale   = '0;
    bus.vp_offset  = '0;
    #1;
    chk("rst ready", bus.ready, 1);
    chk("rst calc_done", bus.calc_done, 0);
    chk("rst clipped", bus.clipped_out, 0);
    chk_vert("rst", 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Perspective batch; inputs scrambled after capture, read_done noise during divide.
    load_t1();
    capture(1'b0);
    chk("t1 ready low", bus.ready, 0);
    set_vert(0, 32'h1234_5678, '0, '0);
    bus.mode = 1'b1;
    set_vp('0, '0);
    wait_done("t1 latency", 300, 1'b1);
    chk_t1("t1");
    repeat (3) @(posedge clk);
    #1;
    chk("t1 done held", bus.calc_done, 1);
    chk("t1 ready in done", bus.ready, 0);
    release_batch(1'b0);
    chk("t1 release ready", bus.ready, 1);
    chk("t1 release calc_done", bus.calc_done, 0);
    chk_vert("t1 idle hold", 0, P640, P160);

    // Vertex 1 rejected by w=0.
    bus.mode = 1'b0;
    set_vp(S320, S320);
    set_vert(0, ONE, '0, ONE);
    set_vert(1, FIVE, FIVE, '0);
    set_vert(2, HALF, MHALF, ONE);
    capture(1'b0);
    wait_done("t2 latency", 204, 1'b0);
    chk_vert("t2", 0, P640, S320);
    chk_vert("t2", 1, '0, '0);
    chk_vert("t2", 2, P480, P160);
    chk("t2 clipped", bus.clipped_out, 3'b010);
    release_batch(1'b0);

    // Orthographic: w ignored, zero/negative w not clipped.
    bus.mode = 1'b1;
    set_vert(0, HALF, '0, 32'h0001_2345);
    set_vert(1, '0, '0, '0);
    set_vert(2, MONE, TWO, MONE);
    capture(1'b0);
    chk("t3 capture clears clipped", bus.clipped_out, 0);
    chk("t3 capture holds v2 y", bus.screen_2d_out[2][1], P160);
    wait_done("t3 latency", 12, 1'b0);
    chk_vert("t3", 0, P480, S320);
    chk_vert("t3", 1, S320, S320);
    chk_vert("t3", 2, '0, P960);
    chk("t3 clipped", bus.clipped_out, 3'b000);
    release_batch(1'b0);

    // Divide saturation, unit viewport.
    bus.mode = 1'b0;
    set_vp(ONE, '0);
    set_vert(0, 32'h7FFF_0000, 32'h8000_0000, 32'h0000_0001);
    set_vert(1, ONE, MONE, ONE);
    set_vert(2, '0, '0, ONE);
    capture(1'b0);
    wait_done("t4 latency", 300, 1'b0);
    chk_vert("t4", 0, 32'h7FFF_FFFF, 32'h8000_0000);
    chk_vert("t4", 1, ONE, MONE);
    chk_vert("t4", 2, '0, '0);
    release_batch(1'b0);

    // data_valid held high; release and recapture on back-to-back edges.
    load_t1();
    capture(1'b1);
    wait_done("t5 latency dv held", 300, 1'b0);
    chk_t1("t5");
    set_vert(0, ONE, MONE, TWO);
    release_batch(1'b1);
    chk("t5 release ready", bus.ready, 1);
    chk("t5 release calc_done", bus.calc_done, 0);
    chk_vert("t5 no capture on release", 0, P640, P160);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    chk("t5 recapture ready", bus.ready, 0);
    wait_done("t5 second latency", 300, 1'b0);
    chk_vert("t5 second", 0, P480, P160);
    release_batch(1'b0);

    // Reset mid-divide, then a fresh batch.
    load_t1();
    capture(1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6 rst ready", bus.ready, 1);
    chk("t6 rst calc_done", bus.calc_done, 0);
    chk("t6 rst clipped", bus.clipped_out, 0);
    chk_vert("t6 rst", 0, '0, '0);
    chk_vert("t6 rst", 1, '0, '0);
    chk_vert("t6 rst", 2, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    capture(1'b0);
    wait_done("t6 latency", 300, 1'b0);
    chk_t1("t6");
    release_batch(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
